// File: rtl/trace_cmd_decoder.sv
// trace_cmd_decoder
// Checks trace command codes, splits the address into tag / set index / byte
// offset and queues decoded commands in a small FIFO for the cache. Illegal
// codes are dropped, flagged with a one-cycle pulse and counted (saturating).

module trace_cmd_decoder #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 32,
    parameter int SETS       = 16384,
    parameter int LINE_BYTES = 64,
    localparam int IDX_W     = $clog2(SETS),
    localparam int OFF_W     = $clog2(LINE_BYTES),
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_n,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_n,
    output logic [TAG_W-1:0]  out_tag,
    output logic [IDX_W-1:0]  out_index,
    output logic [OFF_W-1:0]  out_offset,
    output logic              out_snoop,
    output logic              out_ctrl,
    output logic              illegal,
    output logic [15:0]       illegal_cnt,
    output logic [LVL_W-1:0]  level
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

    // Codes 0-6, 8 and 9 are understood by the cache; everything else is dropped.
    function automatic logic is_legal(input logic [3:0] n);
        logic r;
        case (n)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9: r = 1'b1;
            default:                                              r = 1'b0;
        endcase
        return r;
    endfunction

    // Snoop commands occupy codes 3..6.
    function automatic logic is_snoop(input logic [3:0] n);
        logic r;
        case (n)
            4'd3, 4'd4, 4'd5, 4'd6: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Control commands: 8 = clear, 9 = print.
    function automatic logic is_ctrl(input logic [3:0] n);
        logic r;
        case (n)
            4'd8, 4'd9: r = 1'b1;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    // Entry storage (data only; validity is tracked by the pointers and level)
    logic [3:0]        mem_n    [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             illegal_q, illegal_d;
    logic [15:0]      illegal_cnt_q, illegal_cnt_d;

    logic             accept_s;
    logic             legal_s;
    logic             push_s;
    logic             pop_s;
    logic             valid_s;
    logic [3:0]       head_n_s;
    logic [ADDR_W-1:0] head_addr_s;

    // Handshake qualifiers; in_ready depends only on registered occupancy.
    always_comb begin
        valid_s     = (level_q != {LVL_W{1'b0}});
        in_ready    = (level_q != DEPTH_LVL);
        legal_s     = is_legal(in_n);
        accept_s    = in_valid & in_ready;
        push_s      = accept_s & legal_s;
        pop_s       = valid_s & out_ready;
        head_n_s    = mem_n[rd_ptr_q];
        head_addr_s = mem_addr[rd_ptr_q];
    end

    // Next-state for pointers, occupancy and the illegal-command bookkeeping.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        illegal_d     = accept_s & ~legal_s;
        illegal_cnt_d = illegal_cnt_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (illegal_d && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end else begin
            illegal_cnt_d = illegal_cnt_q;
        end
    end

    // Control state; an asynchronous reset empties the FIFO and clears the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            level_q       <= {LVL_W{1'b0}};
            illegal_q     <= 1'b0;
            illegal_cnt_q <= 16'h0000;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // Entry write on a legal accept; the raw address is kept and sliced on read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_n[wr_ptr_q]    <= in_n;
            mem_addr[wr_ptr_q] <= in_addr;
        end
    end

    // Head-entry decode; fields read zero whenever the FIFO is empty so stale
    // storage never leaks out after reset or drain.
    always_comb begin
        out_valid   = valid_s;
        level       = level_q;
        illegal     = illegal_q;
        illegal_cnt = illegal_cnt_q;
        if (valid_s) begin
            out_n      = head_n_s;
            out_tag    = head_addr_s[ADDR_W-1 -: TAG_W];
            out_index  = head_addr_s[OFF_W +: IDX_W];
            out_offset = head_addr_s[OFF_W-1:0];
            out_snoop  = is_snoop(head_n_s);
            out_ctrl   = is_ctrl(head_n_s);
        end else begin
            out_n      = 4'h0;
            out_tag    = {TAG_W{1'b0}};
            out_index  = {IDX_W{1'b0}};
            out_offset = {OFF_W{1'b0}};
            out_snoop  = 1'b0;
            out_ctrl   = 1'b0;
        end
    end

endmodule
